// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: UART state encoding, idle line level and counter-width helper.
package fifo_uart_tx_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/fifo_uart_tx_baud.sv
// uart_baud_gen: per-bit clock counter; bit_end_o marks the last clock of each serial bit.
module uart_baud_gen #(
  parameter int DIVISOR  = 16,
  parameter int CNT_BITS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic bit_end_o
);
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  assign bit_end_o = en_i && (cnt_q == CNT_BITS'(DIVISOR - 1));
  assign cnt_d = (!en_i || bit_end_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops a fallthrough FIFO and serializes each byte as 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DIVISOR   = 16,
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = clog2_min1(DIVISOR)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_available,
  input  logic [DATA_BITS-1:0] read_data,
  output logic                 read_strobe,
  output logic                 serial,
  output logic                 busy
);
  localparam int BIT_W = $clog2(DATA_BITS) + 1;
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 serial_q, serial_d, strobe_q, pop, bit_end, last_data, data_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  uart_baud_gen #(.DIVISOR(DIVISOR), .CNT_BITS(CNT_BITS)) u_baud (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (state_q != ST_IDLE),
    .bit_end_o (bit_end)
  );
  assign data_end  = state_q == ST_DATA && bit_end;
  assign last_data = data_end && bit_q == BIT_W'(DATA_BITS - 1);
  // The only two pop points; a stale data_available anywhere else is ignored.
  assign pop = data_available && (state_q == ST_IDLE || (state_q == ST_STOP && bit_end));
  assign read_strobe = strobe_q;
  assign serial      = serial_q;
  assign busy        = state_q != ST_IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      serial_q <= UART_IDLE_LEVEL;
      strobe_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      serial_q <= serial_d;
      strobe_q <= pop;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = data_available ? ST_START : ST_IDLE;
      ST_START:  state_d = bit_end ? ST_DATA : ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
      ST_DATA:   state_d = last_data ? ST_PARITY : ST_DATA;
      ST_PARITY: state_d = bit_end ? ST_STOP : ST_PARITY;
`else
      ST_DATA:   state_d = last_data ? ST_STOP : ST_DATA;
`endif
      ST_STOP:   state_d = bit_end ? (data_available ? ST_START : ST_IDLE) : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end
  // serial is computed from the next state so the registered pin lines up with state_q.
  always_comb begin
    shift_d = pop ? read_data : data_end ? shift_q >> 1 : shift_q;
    bit_d   = pop ? '0 : data_end ? bit_q + 1'b1 : bit_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d    = pop ? ^read_data : par_q;
    serial_d = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? shift_d[0] :
               state_d == ST_PARITY ? par_d : UART_IDLE_LEVEL;
`else
    serial_d = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? shift_d[0] : UART_IDLE_LEVEL;
`endif
  end
endmodule
